pipearch_dispatch: RTL and testbench
====================================

# pipearch_dispatch

Instruction dispatcher directly upstream of the PipeArch operation units (copy, compute, etc.). It fetches 128-bit instruction words from a local instruction memory and decodes the opcode. It issues a one-cycle `op_start` with the instruction's register words to the selected unit, then waits for that unit's `op_done` before fetching the next instruction. The whole program can be replayed a configurable number of times before completion is signalled.

## Interface
- `NUM_OPS`, 4: number of attached operation units; opcode range 0..NUM_OPS-1.
- `NUM_REGS`, 2: 32-bit register words forwarded per instruction (max 3).
- `LOG2_PROG`, 10: instruction memory address width.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: program start pulse; ignored while `busy`.
- `prog_length` in LOG2_PROG+1: instructions per pass.
- `prog_repeat` in 16: number of passes; 0 is treated as 1.
- `instr_re` out 1: instruction memory read enable.
- `instr_addr` out LOG2_PROG: instruction read address.
- `instr_rdata` in 128: instruction word, valid exactly 1 cycle after `instr_re`.
- `op_start` out NUM_OPS: one-hot start pulse.
- `op_regs` out NUM_REGS×32: register words to units; held stable from issue until the next issue.
- `op_done` in NUM_OPS: per-unit completion pulses.
- `busy` out 1: program in progress.
- `done` out 1: one-cycle pulse at program end.
- `error` out 1: sticky illegal-opcode flag; cleared by the next accepted `start`.

## Operation
- Instruction word: [31:0] reg0, [63:32] reg1, [95:64] reg2, [103:96] opcode, [127:104] reserved, ignored.
- States are IDLE, FETCH, CAPTURE, ISSUE, WAIT_DONE.
- IDLE: on `start`, clear `pc`, `pass` and `error`.
  - If `prog_length`==0, pulse `done` on the next cycle and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH: assert `instr_re` with `instr_addr`=`pc` for 1 cycle, then go to CAPTURE.
- CAPTURE: register the opcode and regs from `instr_rdata`.
  - If opcode ≥ NUM_OPS: set `error`, pulse `done`, go to IDLE (program aborted, no further fetches).
  - Otherwise go to ISSUE.
- ISSUE: drive `op_start[opcode]`=1 for exactly one cycle and `op_regs` from the captured words, then go to WAIT_DONE.
- WAIT_DONE: wait for `op_done[opcode]`. `op_done` of any other unit is ignored. On the selected unit's done:
  - If `pc` < `prog_length`-1: `pc`++, go to FETCH.
  - Else if `pass` < max(`prog_repeat`,1)-1: `pass`++, `pc`=0, go to FETCH.
  - Else pulse `done`, go to IDLE.
- `pass` is 16 bits and `pc` is LOG2_PROG bits; no wrap is possible because the comparisons bound both counters.
- `prog_length` and `prog_repeat` are sampled at `start` and held internally; later input changes have no effect.

## Timing
- Reset values: `op_start`=0, `op_regs`=0, `instr_re`=0, `instr_addr`=0, `busy`=0, `done`=0, `error`=0; state IDLE.
- All outputs are registered.
- Start to first `op_start`: `start` at cycle T → FETCH at T+1 → CAPTURE at T+2 → `op_start` high at T+3.
- Done to next start: `op_done` sampled at cycle D → `op_start` of the next instruction at D+4.
- `done` is asserted at D+1.
- `busy` is high from T+1 through the cycle `done` is high, inclusive.
- Reset mid-program: return to IDLE next cycle with no `done` pulse.
  - An in-flight unit is reset by the same `reset`; its late `op_done` is ignored in IDLE.
- An `op_done` arriving in any state other than WAIT_DONE is dropped. Units must assert done at least 1 cycle after their start.
- `start` coincident with `reset`: reset wins.

## Configuration
- `PIPEARCH_DISPATCH_CYCLES_EN`
  - Defined: add output `prog_cycles` (32 bits). It clears on an accepted `start`, increments every cycle while `busy`, saturates at 0xFFFFFFFF, and holds its value after `done`.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `pipearch_pkg`:
  - `t_dispatchstate` enum.
  - Instruction field constants: `INSTR_OPCODE_LSB`=96, `INSTR_OPCODE_W`=8, `INSTR_REG_W`=32.
  - 128-bit instruction width constant.
- Sub-module `pipearch_instr_decode`: combinational split of the 128-bit word into opcode, regs and an illegal flag for a given NUM_OPS. The FSM and counters live in the top module.

## Test plan
- Single instruction: `prog_length`=1, `prog_repeat`=1, opcode 0, reg0=0x00050000; unit 0 done 6 cycles after start → `op_start`=4'b0001 at T+3, `op_regs[0]`=0x00050000, `done` exactly once, `error`=0.
- Three instructions with opcodes 1,2,3 and `prog_repeat`=2 → six `op_start` pulses in order 1,2,3,1,2,3, addresses 0,1,2,0,1,2, and `done` after the sixth matching `op_done`.
- Illegal opcode 7 at address 1 of 3 (NUM_OPS=4) → one issue to unit 0, then `error`=1 and `done` pulse; no fetch of address 2.
- Wrong-unit done: unit 2 busy, `op_done[0]` pulsed → ignored; advance only on `op_done[2]`.
- Reset asserted during WAIT_DONE → outputs at reset values next cycle, no `done`. A new `start` runs the program from `pc`=0.
- `prog_length`=0 → `done` at T+1, no `instr_re`, no `op_start`. With `PIPEARCH_DISPATCH_CYCLES_EN` and a 1-instruction program whose done comes at T+8, `prog_cycles`=9.

Source files
------------

// File: rtl/pipearch_pkg.sv
// rtl/pipearch_pkg.sv - shared PipeArch types and instruction field layout
package pipearch_pkg;

  typedef enum logic [2:0] {
    DS_IDLE    = 3'd0,
    DS_FETCH   = 3'd1,
    DS_CAPTURE = 3'd2,
    DS_ISSUE   = 3'd3,
    DS_WAIT    = 3'd4
  } t_dispatchstate;

  localparam int INSTR_W          = 128;
  localparam int INSTR_OPCODE_LSB = 96;
  localparam int INSTR_OPCODE_W   = 8;
  localparam int INSTR_REG_W      = 32;

endpackage

// File: rtl/pipearch_instr_decode.sv
// rtl/pipearch_instr_decode.sv - combinational split of a 128-bit instruction word
module pipearch_instr_decode
  import pipearch_pkg::*;
#(
  parameter int NUM_OPS  = 4,
  parameter int NUM_REGS = 2
) (
  input  logic [INSTR_W-1:0]              instr_i,
  output logic [INSTR_OPCODE_W-1:0]       opcode_o,
  output logic [NUM_REGS*INSTR_REG_W-1:0] regs_o,
  output logic                            illegal_o
);

  localparam logic [INSTR_OPCODE_W:0] OPS_LIMIT = (INSTR_OPCODE_W+1)'(NUM_OPS);

  logic unused_bits;

  assign opcode_o  = instr_i[INSTR_OPCODE_LSB +: INSTR_OPCODE_W];
  assign regs_o    = instr_i[NUM_REGS*INSTR_REG_W-1:0];
  assign illegal_o = {1'b0, opcode_o} >= OPS_LIMIT;

  // Reserved field and any register words beyond NUM_REGS are dropped.
  assign unused_bits = (^instr_i[INSTR_W-1:INSTR_OPCODE_LSB+INSTR_OPCODE_W])
                     ^ (^instr_i[INSTR_OPCODE_LSB-1:0]);

endmodule

// File: rtl/pipearch_dispatch.sv
// rtl/pipearch_dispatch.sv - PipeArch instruction fetch/issue FSM; PIPEARCH_DISPATCH_CYCLES_EN adds prog_cycles
module pipearch_dispatch
  import pipearch_pkg::*;
#(
  parameter int NUM_OPS   = 4,
  parameter int NUM_REGS  = 2,
  parameter int LOG2_PROG = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [LOG2_PROG:0]              prog_length,
  input  logic [15:0]                     prog_repeat,
  output logic                            instr_re,
  output logic [LOG2_PROG-1:0]            instr_addr,
  input  logic [INSTR_W-1:0]              instr_rdata,
  output logic [NUM_OPS-1:0]              op_start,
  output logic [NUM_REGS*INSTR_REG_W-1:0] op_regs,
  input  logic [NUM_OPS-1:0]              op_done,
  output logic                            busy,
  output logic                            done,
  output logic                            error
`ifdef PIPEARCH_DISPATCH_CYCLES_EN
  ,
  output logic [31:0]                     prog_cycles
`endif
);

  localparam int OPW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  localparam logic [2:0] ST_IDLE    = 3'(DS_IDLE);
  localparam logic [2:0] ST_FETCH   = 3'(DS_FETCH);
  localparam logic [2:0] ST_CAPTURE = 3'(DS_CAPTURE);
  localparam logic [2:0] ST_ISSUE   = 3'(DS_ISSUE);
  localparam logic [2:0] ST_WAIT    = 3'(DS_WAIT);

  localparam logic [LOG2_PROG:0] LEN_ONE = (LOG2_PROG+1)'(1);

  logic [2:0]                      state_q, state_d;
  logic [LOG2_PROG-1:0]            pc_q, pc_d;
  logic [15:0]                     pass_q, pass_d;
  logic [LOG2_PROG:0]              len_q, len_d;
  logic [15:0]                     rep_q, rep_d;
  logic [OPW-1:0]                  sel_q, sel_d;
  logic                            re_q, re_d;
  logic [LOG2_PROG-1:0]            addr_q, addr_d;
  logic [NUM_OPS-1:0]              op_start_q, op_start_d;
  logic [NUM_REGS*INSTR_REG_W-1:0] regs_q, regs_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;

  logic [INSTR_OPCODE_W-1:0]       dec_opcode;
  logic [NUM_REGS*INSTR_REG_W-1:0] dec_regs;
  logic                            dec_illegal;
  logic                            start_accept;
  logic                            unused_opcode;

  pipearch_instr_decode #(
    .NUM_OPS  (NUM_OPS),
    .NUM_REGS (NUM_REGS)
  ) u_decode (
    .instr_i   (instr_rdata),
    .opcode_o  (dec_opcode),
    .regs_o    (dec_regs),
    .illegal_o (dec_illegal)
  );

  assign unused_opcode = ^dec_opcode;
  // The done cycle is already back in IDLE but still busy; start is refused there.
  assign start_accept  = (state_q == ST_IDLE) && start && !busy_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pass_d     = pass_q;
    len_d      = len_q;
    rep_d      = rep_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    regs_d     = regs_q;
    err_d      = err_q;
    re_d       = 1'b0;
    op_start_d = '0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_accept) begin
          pc_d   = '0;
          pass_d = '0;
          err_d  = 1'b0;
          len_d  = prog_length;
          rep_d  = (prog_repeat == 16'd0) ? 16'd1 : prog_repeat;
          if (prog_length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
            re_d    = 1'b1;
            addr_d  = '0;
          end
        end
      end
      ST_FETCH: begin
        // Entered from WAIT_DONE with the read not yet launched: issue it from the updated pc.
        if (re_q) begin
          state_d = ST_CAPTURE;
        end else begin
          re_d   = 1'b1;
          addr_d = pc_q;
        end
      end
      ST_CAPTURE: begin
        if (dec_illegal) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          sel_d                         = dec_opcode[OPW-1:0];
          regs_d                        = dec_regs;
          op_start_d[dec_opcode[OPW-1:0]] = 1'b1;
          state_d                       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (op_done[sel_q]) begin
          if ({1'b0, pc_q} < (len_q - LEN_ONE)) begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_FETCH;
          end else if (pass_q < (rep_q - 16'd1)) begin
            pass_d  = pass_q + 16'd1;
            pc_d    = '0;
            state_d = ST_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      pass_q     <= '0;
      len_q      <= '0;
      rep_q      <= '0;
      sel_q      <= '0;
      re_q       <= 1'b0;
      addr_q     <= '0;
      op_start_q <= '0;
      regs_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pass_q     <= pass_d;
      len_q      <= len_d;
      rep_q      <= rep_d;
      sel_q      <= sel_d;
      re_q       <= re_d;
      addr_q     <= addr_d;
      op_start_q <= op_start_d;
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign instr_re   = re_q;
  assign instr_addr = addr_q;
  assign op_start   = op_start_q;
  assign op_regs    = regs_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;

`ifdef PIPEARCH_DISPATCH_CYCLES_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (start_accept) begin
      cyc_d = '0;
    end else if (busy_q && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign prog_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_pipearch_dispatch.sv
// tb/tb_pipearch_dispatch.sv - directed self-checking bench for pipearch_dispatch
module tb_pipearch_dispatch;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [10:0]   prog_length = '0;
  logic [15:0]   prog_repeat = '0;
  logic          instr_re;
  logic [9:0]    instr_addr;
  logic [127:0]  instr_rdata = '0;
  logic [3:0]    op_start;
  logic [63:0]   op_regs;
  logic [3:0]    op_done = '0;
  logic          busy;
  logic          done;
  logic          error;
`ifdef PIPEARCH_DISPATCH_CYCLES_EN
  logic [31:0]   prog_cycles;
`endif

  pipearch_dispatch #(
    .NUM_OPS   (4),
    .NUM_REGS  (2),
    .LOG2_PROG (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_length (prog_length),
    .prog_repeat (prog_repeat),
    .instr_re    (instr_re),
    .instr_addr  (instr_addr),
    .instr_rdata (instr_rdata),
    .op_start    (op_start),
    .op_regs     (op_regs),
    .op_done     (op_done),
    .busy        (busy),
    .done        (done),
    .error       (error)
`ifdef PIPEARCH_DISPATCH_CYCLES_EN
    ,
    .prog_cycles (prog_cycles)
`endif
  );

  always #5 clk = ~clk;

  logic [127:0] mem [0:15];

  always @(posedge clk) begin
    if (instr_re) instr_rdata <= mem[instr_addr[3:0]];
  end

  int n_vec = 0;
  int n_err = 0;

  int          fetch_q[$];
  int          issue_unit_q[$];
  int          issue_cyc_q[$];
  int          issue_val_q[$];
  logic [31:0] issue_r0_q[$];
  logic        busy_log [0:255];
  int          done_cnt;
  int          done_cyc;
  logic        err_at_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [7:0] op, input logic [31:0] r0,
                                      input logic [31:0] r1);
    return {24'hABCDEF, op, 32'hDEAD0002, r1, r0};
  endfunction

  // Starts a program, acts as the operation units (done lat cycles after each issue)
  // and logs fetches, issues and done pulses by cycle number relative to start.
  task automatic run_prog(input logic [10:0] len, input logic [15:0] rep, input int lat,
                          input int spur_at, input int restart_at, input int budget);
    int pend_unit;
    int pend_at;
    pend_unit = -1;
    pend_at   = 0;
    fetch_q.delete();
    issue_unit_q.delete();
    issue_cyc_q.delete();
    issue_val_q.delete();
    issue_r0_q.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    err_at_done = 1'b0;
    prog_length = len;
    prog_repeat = rep;
    start       = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      start = (c == restart_at);
      if (c == 1) begin
        prog_length = '0;
        prog_repeat = 16'd9;
      end
      op_done     = '0;
      busy_log[c] = busy;
      if (instr_re) fetch_q.push_back(int'(instr_addr));
      if (op_start != '0) begin
        for (int u = 0; u < 4; u++) if (op_start[u]) pend_unit = u;
        issue_unit_q.push_back(pend_unit);
        issue_val_q.push_back(int'(op_start));
        issue_cyc_q.push_back(c);
        issue_r0_q.push_back(op_regs[31:0]);
        pend_at = c + lat;
      end
      if (pend_unit >= 0 && c == pend_at) begin
        op_done[pend_unit] = 1'b1;
        pend_unit = -1;
      end
      if (c == spur_at) op_done[0] = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc    = c;
        err_at_done = error;
      end
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    op_done = '0;
    start   = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_op_start", op_start, 0);
    chk("rst_op_regs", op_regs, 0);
    chk("rst_instr_re", instr_re, 0);
    chk("rst_instr_addr", instr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    tick();

    // Single instruction; late start at cycle 4 must be ignored.
    mem[0] = mk(8'd0, 32'h0005_0000, 32'h1111_2222);
    run_prog(11'd1, 16'd1, 3, -1, 4, 40);
    chk("t1_issue_cnt", issue_unit_q.size(), 1);
    chk("t1_issue_cyc", issue_cyc_q[0], 3);
    chk("t1_op_start", issue_val_q[0], 4'b0001);
    chk("t1_reg0", issue_r0_q[0], 32'h0005_0000);
    chk("t1_done_cyc", done_cyc, 7);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_error", err_at_done, 0);
    chk("t1_fetch_cnt", fetch_q.size(), 1);
    chk("t1_busy_first", busy_log[1], 1);
    chk("t1_busy_done", busy_log[7], 1);
    chk("t1_busy_after", busy_log[8], 0);
    chk("t1_regs_held", op_regs, {32'h1111_2222, 32'h0005_0000});

    // Three instructions, two passes; inputs change after start and must be ignored.
    mem[0] = mk(8'd1, 32'hA000_0001, 32'h0);
    mem[1] = mk(8'd2, 32'hA000_0002, 32'h0);
    mem[2] = mk(8'd3, 32'hA000_0003, 32'h0);
    run_prog(11'd3, 16'd2, 2, -1, 0, 80);
    chk("t2_issue_cnt", issue_unit_q.size(), 6);
    for (int i = 0; i < 6 && i < issue_unit_q.size(); i++) begin
      chk($sformatf("t2_unit%0d", i), issue_unit_q[i], (i % 3) + 1);
      chk($sformatf("t2_cyc%0d", i), issue_cyc_q[i], 3 + 6 * i);
    end
    chk("t2_fetch_cnt", fetch_q.size(), 6);
    for (int i = 0; i < 6 && i < fetch_q.size(); i++)
      chk($sformatf("t2_addr%0d", i), fetch_q[i], i % 3);
    if (issue_r0_q.size() > 3) chk("t2_reg0_pass2", issue_r0_q[3], 32'hA000_0001);
    chk("t2_done_cyc", done_cyc, 36);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_error", err_at_done, 0);

    // Illegal opcode at address 1 aborts the program.
    mem[0] = mk(8'd0, 32'hB000_0000, 32'h0);
    mem[1] = mk(8'd7, 32'hB000_0001, 32'h0);
    mem[2] = mk(8'd1, 32'hB000_0002, 32'h0);
    run_prog(11'd3, 16'd1, 2, -1, 0, 40);
    chk("t3_issue_cnt", issue_unit_q.size(), 1);
    chk("t3_fetch_cnt", fetch_q.size(), 2);
    chk("t3_done_cyc", done_cyc, 9);
    chk("t3_error", err_at_done, 1);
    chk("t3_error_sticky", error, 1);
    chk("t3_busy_after", busy_log[10], 0);

    // Wrong-unit done is ignored; error clears on the new start.
    mem[0] = mk(8'd2, 32'hC000_0000, 32'h0);
    run_prog(11'd1, 16'd0, 6, 5, 0, 40);
    chk("t4_op_start", issue_val_q.size() > 0 ? issue_val_q[0] : 0, 4'b0100);
    chk("t4_done_cyc", done_cyc, 10);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_error", err_at_done, 0);

    // Reset while unit 1 is in flight, then its late done arrives in IDLE.
    mem[0] = mk(8'd1, 32'hD000_0000, 32'h0);
    mem[1] = mk(8'd2, 32'hD000_0001, 32'h0);
    mem[2] = mk(8'd3, 32'hD000_0002, 32'h0);
    prog_length = 11'd3;
    prog_repeat = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_op_start", op_start, 0);
    chk("t5_op_regs", op_regs, 0);
    chk("t5_instr_re", instr_re, 0);
    reset = 1'b0;
    op_done = 4'b0010;
    tick();
    op_done = '0;
    chk("t5_idle_done", done, 0);
    tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_re", instr_re, 0);
    run_prog(11'd3, 16'd1, 2, -1, 0, 60);
    chk("t5_rerun_addr0", fetch_q.size() > 0 ? fetch_q[0] : -1, 0);
    chk("t5_rerun_issues", issue_unit_q.size(), 3);
    chk("t5_rerun_done", done_cyc, 18);

    // Empty program completes immediately.
    run_prog(11'd0, 16'd1, 2, -1, 0, 20);
    chk("t6_done_cyc", done_cyc, 1);
    chk("t6_fetch_cnt", fetch_q.size(), 0);
    chk("t6_issue_cnt", issue_unit_q.size(), 0);
    chk("t6_busy", busy_log[1], 1);
    chk("t6_busy_after", busy_log[2], 0);

`ifdef PIPEARCH_DISPATCH_CYCLES_EN
    mem[0] = mk(8'd0, 32'hE000_0000, 32'h0);
    run_prog(11'd1, 16'd1, 5, -1, 0, 40);
    chk("t7_done_cyc", done_cyc, 9);
    chk("t7_prog_cycles", prog_cycles, 9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
